// File: rtl/parity_sched.sv
// parity_sched: four-requester round-robin parity checker sharing one 8-bit
// XOR reduction.
//
// A request is accepted in StIdle, its parity is computed and registered in
// StCompute, and the result is held in StHold until the consumer takes it.
// One result is produced every three cycles at most.
//
// Optional feature: define PARITY_SCHED_ERR_CNT_EN to add a saturating count
// of consumed results that had a parity error (err_clr_i / err_cnt_o).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid_i   per-requester byte pending
//   req_data_i    requester i byte at [8i+7:8i]
//   req_exp_i     per-requester expected parity bit
//   req_ready_o   one-hot grant (only in StIdle)
//   res_valid_o   result presented (StHold)
//   res_ready_i   consumer accepts result
//   res_id_o      requester owning the result
//   res_parity_o  XOR of the captured byte
//   res_err_o     parity differs from the captured expected bit
//   busy_o        FSM not idle
//   err_clr_i     (optional) clear the error counter
//   err_cnt_o     (optional) saturating error count

module parity_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid_i,
  input  logic [31:0] req_data_i,
  input  logic [3:0]  req_exp_i,
  output logic [3:0]  req_ready_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [1:0]  res_id_o,
  output logic        res_parity_o,
  output logic        res_err_o,
  output logic        busy_o
`ifdef PARITY_SCHED_ERR_CNT_EN
  ,
  input  logic        err_clr_i,
  output logic [7:0]  err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCompute = 2'd1,
    StHold    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] data_q, data_d;
  logic       exp_q, exp_d;
  logic [1:0] id_q, id_d;
  logic       parity_q, parity_d;
  logic       err_q, err_d;

  // Round-robin arbitration signals.
  logic [1:0] win_id;
  logic       win_found;
  logic [3:0] grant;
  logic [1:0] idx;
  logic       transfer;
  logic       consume;

  // --------------------------------------------------------------------------
  // Round-robin search: ptr, ptr+1, ptr+2, ptr+3 (2-bit arithmetic wraps).
  // --------------------------------------------------------------------------
  always_comb begin
    win_id    = 2'd0;
    win_found = 1'b0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win_found && req_valid_i[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
    grant = win_found ? (4'b0001 << win_id) : 4'b0000;
  end

  assign transfer = (state_q == StIdle) && win_found;
  assign consume  = (state_q == StHold) && res_ready_i;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    exp_d    = exp_q;
    id_d     = id_q;
    parity_d = parity_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          data_d  = req_data_i[8*win_id +: 8];
          exp_d   = req_exp_i[win_id];
          id_d    = win_id;
          ptr_d   = win_id + 2'd1;
          state_d = StCompute;
        end
      end
      StCompute: begin
        // The single shared reduction: only the captured byte feeds it.
        parity_d = ^data_q;
        err_d    = (^data_q) ^ exp_q;
        state_d  = StHold;
      end
      StHold: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 2'd0;
      data_q   <= 8'd0;
      exp_q    <= 1'b0;
      id_q     <= 2'd0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      exp_q    <= exp_d;
      id_q     <= id_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready_o  = (state_q == StIdle) ? grant : 4'b0000;
    res_valid_o  = (state_q == StHold);
    busy_o       = (state_q != StIdle);
    res_id_o     = id_q;
    res_parity_o = parity_q;
    res_err_o    = err_q;
  end

`ifdef PARITY_SCHED_ERR_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating error counter; a clear beats a same-cycle increment.
  // --------------------------------------------------------------------------
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = 8'd0;
    end else if (consume && err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  // Consume only matters to the optional counter.
  logic unused_consume;
  assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_parity_sched.sv
// Self-checking bench for parity_sched: a table of single transactions
// followed by hand-written multi-cycle sequences.

module tb_parity_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_exp;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic        res_parity;
  logic        res_err;
  logic        busy;
`ifdef PARITY_SCHED_ERR_CNT_EN
  logic        err_clr;
  logic [7:0]  err_cnt;
`endif

  parity_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_exp_i    (req_exp),
    .req_ready_o  (req_ready),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_id_o     (res_id),
    .res_parity_o (res_parity),
    .res_err_o    (res_err),
    .busy_o       (busy)
`ifdef PARITY_SCHED_ERR_CNT_EN
    ,
    .err_clr_i    (err_clr),
    .err_cnt_o    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp;
    logic [3:0]  grant;
    logic [1:0]  id;
    logic        par;
    logic        err;
  } vec_t;

  localparam int NumVec = 10;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction with res_ready held high; valid drops after the transfer.
  task automatic run_txn(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    req_valid = v.valid;
    req_data  = v.data;
    req_exp   = v.exp;
    res_ready = 1'b1;
    #1;
    check({tag, " grant"}, 32'(req_ready), 32'(v.grant));
    if (v.grant == 4'b0000) begin
      step();
      check({tag, " idle busy"}, 32'(busy), 32'd0);
    end else begin
      step();
      req_valid = 4'b0000;
      #1;
      check({tag, " compute busy"}, 32'(busy), 32'd1);
      check({tag, " compute ready"}, 32'(req_ready), 32'd0);
      check({tag, " compute valid"}, 32'(res_valid), 32'd0);
      step();
      check({tag, " res_valid"}, 32'(res_valid), 32'd1);
      check({tag, " res_id"}, 32'(res_id), 32'(v.id));
      check({tag, " res_parity"}, 32'(res_parity), 32'(v.par));
      check({tag, " res_err"}, 32'(res_err), 32'(v.err));
      step();
      check({tag, " consumed"}, 32'(res_valid), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
    end
  endtask

  // Bytes used by the held-valid sequence: parities 0,0,1,1.
  logic [31:0] rr_data;
  logic [1:0]  rr_id [5];
  logic        rr_par [4];

  initial begin
    //              valid    data          exp      grant    id    par   err
    vecs[0] = '{4'b0001, 32'h1234_56A5, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{4'b0001, 32'hFFFF_FF01, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[2] = '{4'b0101, 32'h0007_FFFF, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[3] = '{4'b1111, 32'hFF00_0000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b1};
    vecs[4] = '{4'b1110, 32'h0000_8000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5] = '{4'b0011, 32'hFFFF_FF00, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1};
    vecs[6] = '{4'b1000, 32'h3C00_0000, 4'b0111, 4'b1000, 2'd3, 1'b0, 1'b0};
    vecs[7] = '{4'b1010, 32'h0000_FE00, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[8] = '{4'b0000, 32'hDEAD_BEEF, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[9] = '{4'b0110, 32'h0055_0000, 4'b0010, 4'b0100, 2'd2, 1'b0, 1'b0};

    rr_data = 32'h0107_00A5;
    rr_id[0] = 2'd0; rr_id[1] = 2'd1; rr_id[2] = 2'd2; rr_id[3] = 2'd3; rr_id[4] = 2'd0;
    rr_par[0] = 1'b0; rr_par[1] = 1'b0; rr_par[2] = 1'b1; rr_par[3] = 1'b1;

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    req_exp   = 4'b0000;
    res_ready = 1'b0;
`ifdef PARITY_SCHED_ERR_CNT_EN
    err_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset res_id", 32'(res_id), 32'd0);
    check("reset res_parity", 32'(res_parity), 32'd0);
    check("reset res_err", 32'(res_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < NumVec; i++) begin
      run_txn(vecs[i], i);
    end

    // ---- held valid, all requesters: grants 0,1,2,3,0 from a fresh ptr ----
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    req_data  = rr_data;
    req_exp   = 4'b0000;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr%0d grant", k), 32'(req_ready), 32'(4'b0001 << rr_id[k]));
      step();
      check($sformatf("rr%0d compute ready", k), 32'(req_ready), 32'd0);
      step();
      check($sformatf("rr%0d res_valid", k), 32'(res_valid), 32'd1);
      check($sformatf("rr%0d res_id", k), 32'(res_id), 32'(rr_id[k]));
      check($sformatf("rr%0d res_parity", k), 32'(res_parity), 32'(rr_par[rr_id[k]]));
      step();
    end
    req_valid = 4'b0000;

    // ---- backpressure: id 3, byte 01, exp 0 held for 5 cycles (ptr = 1) ----
    req_valid = 4'b1000;
    req_data  = 32'h0100_0000;
    req_exp   = 4'b0000;
    res_ready = 1'b0;
    #1;
    check("bp grant", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d res_valid", k), 32'(res_valid), 32'd1);
      check($sformatf("bp%0d res_id", k), 32'(res_id), 32'd3);
      check($sformatf("bp%0d res_err", k), 32'(res_err), 32'd1);
      check($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 4'b0000;
    res_ready = 1'b1;
    step();
    check("bp consumed", 32'(res_valid), 32'd0);
    // Offer then withdraw before any edge: ptr must stay at 0.
    req_valid = 4'b1001;
    #1;
    check("withdraw offer", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;
    step();
    req_valid = 4'b1001;
    #1;
    check("withdraw ptr kept", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;

    // ---- reset during HOLD ----
    req_valid = 4'b0100;
    req_data  = 32'h00FF_0000;
    res_ready = 1'b0;
    #1;
    check("rst grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    step();
    check("rst in hold", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn('{4'b1001, 32'h0000_0070, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1}, 100);

    // ---- requester 2 flickers while requester 0 is in HOLD (ptr = 1) ----
    req_valid = 4'b0001;
    req_data  = 32'h0000_0003;
    req_exp   = 4'b0000;
    res_ready = 1'b0;
    #1;
    check("flick grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    step();
    req_valid = 4'b0100;
    #1;
    check("flick no grant", 32'(req_ready), 32'd0);
    check("flick hold", 32'(res_valid), 32'd1);
    step();
    req_valid = 4'b0000;
    step();
    check("flick still hold", 32'(res_valid), 32'd1);
    check("flick id", 32'(res_id), 32'd0);
    res_ready = 1'b1;
    step();
    check("flick consumed", 32'(res_valid), 32'd0);
    req_valid = 4'b0101;
    #1;
    check("flick ptr1", 32'(req_ready), 32'b0100);
    req_valid = 4'b0000;

`ifdef PARITY_SCHED_ERR_CNT_EN
    // ---- error counter ----
    rst_n = 1'b0;
    #1;
    check("cnt reset", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_data  = 32'h0000_0001;
    req_exp   = 4'b0000;
    res_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0000;
      step();
      step();
      if (k == 0) check("cnt first", 32'(err_cnt), 32'd1);
    end
    check("cnt saturate", 32'(err_cnt), 32'd255);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("cnt clr wins", 32'(err_cnt), 32'd0);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    step();
    check("cnt after clr", 32'(err_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
